// File: rtl/rs_multi_if.sv
// Decoder issue port, CDB broadcast and ALU dispatch bundle for rs_multi.
// master = decoder/CDB/ALU side, slave = reservation station.
interface rs_multi_if #(
   parameter int ROB_BITS = 4,
   parameter int NUM_CDB  = 2,
   parameter int CNT_W    = 5
);
   logic                        issue_valid_in;
   logic                        issue_ready_out;
   logic [6:0]                  issue_op_type_in;
   logic [2:0]                  issue_op_in;
   logic                        issue_op_add_in;
   logic [31:0]                 issue_v1_in;
   logic [31:0]                 issue_v2_in;
   logic                        issue_dep1_in;
   logic                        issue_dep2_in;
   logic [ROB_BITS-1:0]         issue_q1_in;
   logic [ROB_BITS-1:0]         issue_q2_in;
   logic [ROB_BITS-1:0]         issue_rd_rob_in;
   logic [31:0]                 issue_pc_in;

   logic [NUM_CDB-1:0]          cdb_valid_in;
   logic [NUM_CDB*ROB_BITS-1:0] cdb_rob_in;
   logic [NUM_CDB*32-1:0]       cdb_value_in;

   logic                        ex_valid_out;
   logic                        ex_ready_in;
   logic [31:0]                 ex_v1_out;
   logic [31:0]                 ex_v2_out;
   logic [6:0]                  ex_op_type_out;
   logic [2:0]                  ex_op_out;
   logic                        ex_op_add_out;
   logic [ROB_BITS-1:0]         ex_rob_out;
   logic [31:0]                 ex_pc_out;

   logic [CNT_W-1:0]            count_out;
   logic                        full_out;

   modport master (
      output issue_valid_in, issue_op_type_in, issue_op_in, issue_op_add_in,
             issue_v1_in, issue_v2_in, issue_dep1_in, issue_dep2_in,
             issue_q1_in, issue_q2_in, issue_rd_rob_in, issue_pc_in,
             cdb_valid_in, cdb_rob_in, cdb_value_in, ex_ready_in,
      input  issue_ready_out, ex_valid_out, ex_v1_out, ex_v2_out,
             ex_op_type_out, ex_op_out, ex_op_add_out, ex_rob_out, ex_pc_out,
             count_out, full_out
   );

   modport slave (
      input  issue_valid_in, issue_op_type_in, issue_op_in, issue_op_add_in,
             issue_v1_in, issue_v2_in, issue_dep1_in, issue_dep2_in,
             issue_q1_in, issue_q2_in, issue_rd_rob_in, issue_pc_in,
             cdb_valid_in, cdb_rob_in, cdb_value_in, ex_ready_in,
      output issue_ready_out, ex_valid_out, ex_v1_out, ex_v2_out,
             ex_op_type_out, ex_op_out, ex_op_add_out, ex_rob_out, ex_pc_out,
             count_out, full_out
   );
endinterface

// File: rtl/rs_multi.sv
// Reservation station: holds ops until operands resolve via multi-channel CDB,
// dispatches the oldest ready entry into a registered valid/ready output stage.
module rs_multi #(
   parameter int RS_SIZE  = 16,
   parameter int ROB_BITS = 4,
   parameter int NUM_CDB  = 2,
   parameter int CNT_W    = $clog2(RS_SIZE+1)
) (
   input  logic      clk_in,
   input  logic      rst_n_in,
   input  logic      rdy_in,
   input  logic      flush_in,
   rs_multi_if.slave bus
);
   localparam int IDX_W = $clog2(RS_SIZE);

   logic [RS_SIZE-1:0]  busy_q, dep1_q, dep2_q, add_q;
   logic [ROB_BITS-1:0] q1_q   [RS_SIZE];
   logic [ROB_BITS-1:0] q2_q   [RS_SIZE];
   logic [ROB_BITS-1:0] rob_q  [RS_SIZE];
   logic [31:0]         v1_q   [RS_SIZE];
   logic [31:0]         v2_q   [RS_SIZE];
   logic [31:0]         pc_q   [RS_SIZE];
   logic [6:0]          type_q [RS_SIZE];
   logic [2:0]          op_q   [RS_SIZE];
   // age_q[i][j] set means entry i was issued before entry j
   logic [RS_SIZE-1:0]  age_q  [RS_SIZE];
   logic [CNT_W-1:0]    count_q, count_d;

   logic                ex_valid_q, ex_add_q;
   logic [31:0]         ex_v1_q, ex_v2_q, ex_pc_q;
   logic [6:0]          ex_type_q;
   logic [2:0]          ex_op_q;
   logic [ROB_BITS-1:0] ex_rob_q;

   logic                full, issue_acc, can_load, do_load;
   logic [RS_SIZE-1:0]  ready, sel_oh, wake1, wake2;
   logic [31:0]         wval1 [RS_SIZE];
   logic [31:0]         wval2 [RS_SIZE];
   logic [IDX_W-1:0]    sel_idx, free_idx;
   logic                byp1, byp2;
   logic [31:0]         byp_v1, byp_v2;

   assign full      = (count_q == CNT_W'(RS_SIZE));
   assign ready     = busy_q & ~dep1_q & ~dep2_q;
   assign issue_acc = bus.issue_valid_in && !full;
   assign can_load  = !ex_valid_q || bus.ex_ready_in;
   assign do_load   = can_load && (|ready);
   assign count_d   = count_q + CNT_W'(issue_acc) - CNT_W'(do_load);

   // CDB match: channels scanned high to low so the lowest index wins
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         wake1[i] = 1'b0;
         wake2[i] = 1'b0;
         wval1[i] = '0;
         wval2[i] = '0;
         for (int c = NUM_CDB-1; c >= 0; c--) begin
            if (bus.cdb_valid_in[c] && bus.cdb_rob_in[c*ROB_BITS +: ROB_BITS] == q1_q[i]) begin
               wake1[i] = 1'b1;
               wval1[i] = bus.cdb_value_in[c*32 +: 32];
            end
            if (bus.cdb_valid_in[c] && bus.cdb_rob_in[c*ROB_BITS +: ROB_BITS] == q2_q[i]) begin
               wake2[i] = 1'b1;
               wval2[i] = bus.cdb_value_in[c*32 +: 32];
            end
         end
         wake1[i] = wake1[i] & busy_q[i] & dep1_q[i];
         wake2[i] = wake2[i] & busy_q[i] & dep2_q[i];
      end
   end

   always_comb begin
      byp1   = 1'b0;
      byp2   = 1'b0;
      byp_v1 = bus.issue_v1_in;
      byp_v2 = bus.issue_v2_in;
      for (int c = NUM_CDB-1; c >= 0; c--) begin
         if (bus.issue_dep1_in && bus.cdb_valid_in[c] &&
             bus.cdb_rob_in[c*ROB_BITS +: ROB_BITS] == bus.issue_q1_in) begin
            byp1   = 1'b1;
            byp_v1 = bus.cdb_value_in[c*32 +: 32];
         end
         if (bus.issue_dep2_in && bus.cdb_valid_in[c] &&
             bus.cdb_rob_in[c*ROB_BITS +: ROB_BITS] == bus.issue_q2_in) begin
            byp2   = 1'b1;
            byp_v2 = bus.cdb_value_in[c*32 +: 32];
         end
      end
   end

   // Oldest ready: no other ready entry is older than it
   always_comb begin
      sel_oh = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         sel_oh[i] = ready[i];
         for (int j = 0; j < RS_SIZE; j++) begin
            if (ready[j] && age_q[j][i]) sel_oh[i] = 1'b0;
         end
      end
      sel_idx = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (sel_oh[i]) sel_idx = IDX_W'(i);
      end
      free_idx = '0;
      for (int i = RS_SIZE-1; i >= 0; i--) begin
         if (!busy_q[i]) free_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy_q     <= '0;
         dep1_q     <= '0;
         dep2_q     <= '0;
         count_q    <= '0;
         ex_valid_q <= 1'b0;
         ex_v1_q    <= '0;
         ex_v2_q    <= '0;
         ex_pc_q    <= '0;
         ex_type_q  <= '0;
         ex_op_q    <= '0;
         ex_add_q   <= 1'b0;
         ex_rob_q   <= '0;
         for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
      end else if (rdy_in) begin
         if (flush_in) begin
            busy_q     <= '0;
            dep1_q     <= '0;
            dep2_q     <= '0;
            count_q    <= '0;
            ex_valid_q <= 1'b0;
            for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
         end else begin
            dep1_q <= dep1_q & ~wake1;
            dep2_q <= dep2_q & ~wake2;
            if (do_load) begin
               busy_q[sel_idx] <= 1'b0;
               ex_valid_q      <= 1'b1;
               ex_v1_q         <= v1_q[sel_idx];
               ex_v2_q         <= v2_q[sel_idx];
               ex_pc_q         <= pc_q[sel_idx];
               ex_type_q       <= type_q[sel_idx];
               ex_op_q         <= op_q[sel_idx];
               ex_add_q        <= add_q[sel_idx];
               ex_rob_q        <= rob_q[sel_idx];
            end else if (can_load) begin
               ex_valid_q <= 1'b0;
            end
            if (issue_acc) begin
               busy_q[free_idx] <= 1'b1;
               dep1_q[free_idx] <= bus.issue_dep1_in && !byp1;
               dep2_q[free_idx] <= bus.issue_dep2_in && !byp2;
               age_q[free_idx]  <= '0;
               for (int j = 0; j < RS_SIZE; j++) begin
                  if (IDX_W'(j) != free_idx) age_q[j][free_idx] <= 1'b1;
               end
            end
            if (do_load) begin
               for (int j = 0; j < RS_SIZE; j++) begin
                  age_q[sel_idx][j] <= 1'b0;
                  age_q[j][sel_idx] <= 1'b0;
               end
            end
            count_q <= count_d;
         end
      end
   end

   // Entry payload needs no reset: it is only read while busy
   always_ff @(posedge clk_in) begin
      if (rdy_in && !flush_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (wake1[i]) v1_q[i] <= wval1[i];
            if (wake2[i]) v2_q[i] <= wval2[i];
         end
         if (issue_acc) begin
            v1_q[free_idx]   <= byp_v1;
            v2_q[free_idx]   <= byp_v2;
            q1_q[free_idx]   <= bus.issue_q1_in;
            q2_q[free_idx]   <= bus.issue_q2_in;
            rob_q[free_idx]  <= bus.issue_rd_rob_in;
            pc_q[free_idx]   <= bus.issue_pc_in;
            type_q[free_idx] <= bus.issue_op_type_in;
            op_q[free_idx]   <= bus.issue_op_in;
            add_q[free_idx]  <= bus.issue_op_add_in;
         end
      end
   end

   assign bus.issue_ready_out = !full;
   assign bus.full_out        = full;
   assign bus.count_out       = count_q;
   assign bus.ex_valid_out    = ex_valid_q;
   assign bus.ex_v1_out       = ex_v1_q;
   assign bus.ex_v2_out       = ex_v2_q;
   assign bus.ex_pc_out       = ex_pc_q;
   assign bus.ex_op_type_out  = ex_type_q;
   assign bus.ex_op_out       = ex_op_q;
   assign bus.ex_op_add_out   = ex_add_q;
   assign bus.ex_rob_out      = ex_rob_q;
endmodule

// File: tb/tb_rs_multi.sv
// Scoreboard bench for rs_multi: queue-based reference model predicts dispatch
// order and occupancy; a negedge monitor checks every cycle and every transfer.
module tb_rs_multi;
   localparam int RS_SIZE  = 16;
   localparam int ROB_BITS = 4;
   localparam int NUM_CDB  = 2;
   localparam int CNT_W    = 5;

   logic clk, rst_n, rdy, flush;
   int   n_tests = 0;
   int   n_fail  = 0;

   rs_multi_if #(.ROB_BITS(ROB_BITS), .NUM_CDB(NUM_CDB), .CNT_W(CNT_W)) bus ();

   rs_multi #(.RS_SIZE(RS_SIZE), .ROB_BITS(ROB_BITS), .NUM_CDB(NUM_CDB), .CNT_W(CNT_W)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .rdy_in   (rdy),
      .flush_in (flush),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit d1, d2;
      bit [3:0] q1, q2, rob;
      bit [31:0] v1, v2, pc;
      bit [6:0] ot;
      bit [2:0] op;
      bit add;
   } ent_t;

   ent_t ents[$];
   ent_t exp_q[$];
   int   m_cnt = 0;
   bit   m_exv = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void cdb_lookup(input bit [3:0] tag, output bit h, output bit [31:0] v);
      h = 1'b0;
      v = '0;
      for (int c = 0; c < NUM_CDB; c++) begin
         if (!h && bus.cdb_valid_in[c] && bus.cdb_rob_in[c*ROB_BITS +: ROB_BITS] == tag) begin
            h = 1'b1;
            v = bus.cdb_value_in[c*32 +: 32];
         end
      end
   endfunction

   // Reference model: ents kept in issue order, so the oldest ready is the first ready
   always @(posedge clk) begin : model
      int   k;
      int   cnt0;
      bit   acc, h;
      bit [31:0] v;
      ent_t e;
      if (!rst_n) begin
         ents.delete();
         exp_q.delete();
         m_exv = 1'b0;
         m_cnt = 0;
      end else if (rdy) begin
         if (flush) begin
            ents.delete();
            exp_q.delete();
            m_exv = 1'b0;
         end else begin
            cnt0 = ents.size();
            acc  = bus.issue_valid_in && (cnt0 < RS_SIZE);
            if (!m_exv || bus.ex_ready_in) begin
               k = -1;
               foreach (ents[i]) if (k < 0 && !ents[i].d1 && !ents[i].d2) k = i;
               if (k >= 0) begin
                  exp_q.push_back(ents[k]);
                  ents.delete(k);
                  m_exv = 1'b1;
               end else begin
                  m_exv = 1'b0;
               end
            end
            foreach (ents[i]) begin
               if (ents[i].d1) begin
                  cdb_lookup(ents[i].q1, h, v);
                  if (h) begin ents[i].d1 = 1'b0; ents[i].v1 = v; end
               end
               if (ents[i].d2) begin
                  cdb_lookup(ents[i].q2, h, v);
                  if (h) begin ents[i].d2 = 1'b0; ents[i].v2 = v; end
               end
            end
            if (acc) begin
               e.d1 = bus.issue_dep1_in; e.d2 = bus.issue_dep2_in;
               e.q1 = bus.issue_q1_in;   e.q2 = bus.issue_q2_in;
               e.v1 = bus.issue_v1_in;   e.v2 = bus.issue_v2_in;
               e.rob = bus.issue_rd_rob_in; e.pc = bus.issue_pc_in;
               e.ot = bus.issue_op_type_in; e.op = bus.issue_op_in;
               e.add = bus.issue_op_add_in;
               if (e.d1) begin cdb_lookup(e.q1, h, v); if (h) begin e.d1 = 1'b0; e.v1 = v; end end
               if (e.d2) begin cdb_lookup(e.q2, h, v); if (h) begin e.d2 = 1'b0; e.v2 = v; end end
               ents.push_back(e);
            end
         end
         m_cnt = ents.size();
      end
   end

   // Monitor: away from the active edge, compare status and the presented op
   always @(negedge clk) begin : monitor
      ent_t o;
      if (rst_n) begin
         chk("count", bus.count_out, m_cnt);
         chk("full", bus.full_out, m_cnt == RS_SIZE);
         chk("issue_ready", bus.issue_ready_out, m_cnt < RS_SIZE);
         chk("ex_valid", bus.ex_valid_out, m_exv);
         if (bus.ex_valid_out) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL ex_unexpected: got rob %0h expected no op", bus.ex_rob_out);
            end else begin
               o = exp_q[0];
               chk("ex_v1", bus.ex_v1_out, o.v1);
               chk("ex_v2", bus.ex_v2_out, o.v2);
               chk("ex_rob", bus.ex_rob_out, o.rob);
               chk("ex_pc", bus.ex_pc_out, o.pc);
               chk("ex_op_type", bus.ex_op_type_out, o.ot);
               chk("ex_op", bus.ex_op_out, o.op);
               chk("ex_op_add", bus.ex_op_add_out, o.add);
               if (bus.ex_ready_in && rdy && !flush) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rdy = 1'b1;
      flush = 1'b0;
      bus.issue_valid_in = 1'b0;
      bus.issue_dep1_in = 1'b0;
      bus.issue_dep2_in = 1'b0;
      bus.cdb_valid_in = '0;
   endtask

   task automatic set_issue(input bit [31:0] v1, input bit [31:0] v2, input bit d1, input bit [3:0] q1,
                            input bit d2, input bit [3:0] q2, input bit [3:0] rob);
      bus.issue_valid_in   = 1'b1;
      bus.issue_v1_in      = v1;
      bus.issue_v2_in      = v2;
      bus.issue_dep1_in    = d1;
      bus.issue_q1_in      = q1;
      bus.issue_dep2_in    = d2;
      bus.issue_q2_in      = q2;
      bus.issue_rd_rob_in  = rob;
      bus.issue_pc_in      = $urandom;
      bus.issue_op_type_in = 7'($urandom);
      bus.issue_op_in      = 3'($urandom);
      bus.issue_op_add_in  = 1'($urandom);
   endtask

   task automatic drain();
      idle();
      bus.ex_ready_in = 1'b1;
      for (int t = 0; t < 16; t++) begin
         bus.cdb_valid_in = 2'b01;
         bus.cdb_rob_in[0 +: ROB_BITS] = 4'(t);
         bus.cdb_value_in[0 +: 32] = $urandom;
         tick();
      end
      bus.cdb_valid_in = '0;
      repeat (24) tick();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      bus.ex_ready_in = 1'b1;
      bus.issue_op_type_in = '0; bus.issue_op_in = '0; bus.issue_op_add_in = 1'b0;
      bus.issue_v1_in = '0; bus.issue_v2_in = '0; bus.issue_q1_in = '0; bus.issue_q2_in = '0;
      bus.issue_rd_rob_in = '0; bus.issue_pc_in = '0;
      bus.cdb_rob_in = '0; bus.cdb_value_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_ex_valid", bus.ex_valid_out, 0);
      chk("rst_count", bus.count_out, 0);
      chk("rst_full", bus.full_out, 0);
      chk("rst_issue_ready", bus.issue_ready_out, 1);
      chk("rst_ex_v1", bus.ex_v1_out, 0);
      chk("rst_ex_rob", bus.ex_rob_out, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // ADDI with no deps
      set_issue(32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
      bus.issue_op_type_in = 7'h13;
      tick();
      idle();
      @(negedge clk);
      chk("addi_count_busy", bus.count_out, 1);
      tick();
      @(negedge clk);
      chk("addi_valid", bus.ex_valid_out, 1);
      chk("addi_v1", bus.ex_v1_out, 5);
      chk("addi_v2", bus.ex_v2_out, 7);
      chk("addi_rob", bus.ex_rob_out, 3);
      chk("addi_count", bus.count_out, 0);
      tick();

      // A waits on tag 6, B ready: B goes first, A gets 0x1234 from channel 1
      set_issue(32'd0, 32'd11, 1'b1, 4'd6, 1'b0, 4'd0, 4'd1);
      tick();
      set_issue(32'd21, 32'd22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
      tick();
      idle();
      repeat (2) tick();
      bus.cdb_valid_in = 2'b10;
      bus.cdb_rob_in[ROB_BITS +: ROB_BITS] = 4'd6;
      bus.cdb_value_in[32 +: 32] = 32'h1234;
      tick();
      idle();
      repeat (4) tick();

      // Issue bypass on dep2 from channel 0
      set_issue(32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd2, 4'd5);
      bus.cdb_valid_in = 2'b01;
      bus.cdb_rob_in[0 +: ROB_BITS] = 4'd2;
      bus.cdb_value_in[0 +: 32] = 32'd99;
      tick();
      idle();
      @(negedge clk);
      chk("byp_count", bus.count_out, 1);
      tick();
      @(negedge clk);
      chk("byp_v2", bus.ex_v2_out, 99);
      tick();
      repeat (3) tick();

      // Fill under back-pressure, then try extra issues
      bus.ex_ready_in = 1'b0;
      for (int n = 0; n < RS_SIZE + 4; n++) begin
         set_issue($urandom, $urandom, 1'b0, 4'd0, 1'b0, 4'd0, 4'(n));
         tick();
      end
      idle();
      @(negedge clk);
      chk("fill_count", bus.count_out, RS_SIZE);
      chk("fill_full", bus.full_out, 1);
      chk("fill_issue_ready", bus.issue_ready_out, 0);
      tick();
      drain();

      // Three ready entries, ALU ready toggling
      bus.ex_ready_in = 1'b0;
      for (int n = 0; n < 3; n++) begin
         set_issue($urandom, $urandom, 1'b0, 4'd0, 1'b0, 4'd0, 4'(8 + n));
         tick();
      end
      idle();
      bus.ex_ready_in = 1'b0;
      for (int n = 0; n < 8; n++) begin
         bus.ex_ready_in = n[0];
         tick();
      end
      drain();

      // Flush with five busy and a held output
      bus.ex_ready_in = 1'b0;
      for (int n = 0; n < 6; n++) begin
         set_issue($urandom, $urandom, 1'b0, 4'd0, 1'b0, 4'd0, 4'(n));
         tick();
      end
      idle();
      bus.ex_ready_in = 1'b0;
      @(negedge clk);
      chk("preflush_count", bus.count_out, 5);
      chk("preflush_valid", bus.ex_valid_out, 1);
      tick();
      flush = 1'b1;
      set_issue(32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
      tick();
      idle();
      @(negedge clk);
      chk("flush_count", bus.count_out, 0);
      chk("flush_valid", bus.ex_valid_out, 0);
      tick();
      bus.ex_ready_in = 1'b1;
      set_issue(32'd77, 32'd88, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
      tick();
      idle();
      repeat (3) tick();

      // Stream with rdy_in dropped for three cycles
      for (int n = 0; n < 10; n++) begin
         set_issue($urandom, $urandom, 1'b0, 4'd0, 1'b0, 4'd0, 4'(n));
         rdy = !(n >= 3 && n < 6);
         tick();
      end
      drain();

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         rdy   = ($urandom_range(0, 9) != 0);
         flush = ($urandom_range(0, 149) == 0);
         bus.ex_ready_in = ($urandom_range(0, 9) < 7);
         set_issue($urandom, $urandom, ($urandom_range(0, 2) == 0), 4'($urandom),
                   ($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom));
         bus.issue_valid_in = ($urandom_range(0, 9) < 6);
         for (int c = 0; c < NUM_CDB; c++) begin
            bus.cdb_valid_in[c] = 1'($urandom);
            bus.cdb_rob_in[c*ROB_BITS +: ROB_BITS] = 4'($urandom);
            bus.cdb_value_in[c*32 +: 32] = $urandom;
         end
         tick();
      end
      drain();

      @(negedge clk);
      chk("final_count", bus.count_out, 0);
      chk("final_pending", exp_q.size(), 0);
      chk("final_model_empty", ents.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
